// File: rtl/apb_slave_regs_pkg.sv
// apb_slave_regs_pkg: shared types, constants and decode helper for the APB register completer.
package apb_slave_regs_pkg;
    localparam int APB_NUM_SLV = 3;
    localparam int APB_NUM_REGS = 8;
    localparam logic [31:0] APB_ERR_RDATA = 32'hDEAD_BEEF;

    typedef enum logic [1:0] {APB_IDLE, APB_SETUP, APB_ACCESS} apb_state_e;

    // Undecodable unless exactly one bank is selected and the address is word aligned.
    function automatic logic bad_decode(input logic [31:0] sel, input logic [1:0] lsb);
        return (sel == '0) || ((sel & (sel - 32'd1)) != '0) || (|lsb);
    endfunction
endpackage

// File: rtl/apb_slave_regs_if.sv
// apb_slave_regs_if: APB bus between the bridge (master) and the register completer (slave).
interface apb_slave_regs_if
    import apb_slave_regs_pkg::*;
#(
    parameter int NUM_SLV = APB_NUM_SLV
);
    logic [NUM_SLV-1:0] Pselx;
    logic [31:0]        Paddr;
    logic [31:0]        Pwdata;
    logic               Penable;
    logic               Pwrite;
    logic [31:0]        Prdata;

    modport master (output Pselx, Paddr, Pwdata, Penable, Pwrite, input Prdata);
    modport slave (input Pselx, Paddr, Pwdata, Penable, Pwrite, output Prdata);
endinterface

// File: rtl/apb_reg_bank.sv
// apb_reg_bank: NUM_REGS x 32-bit register file with one write port and a combinational read port.
module apb_reg_bank
    import apb_slave_regs_pkg::*;
#(
    parameter int NUM_REGS = APB_NUM_REGS,
    parameter int IDX_W    = $clog2(NUM_REGS)
) (
    input  logic             Hclk,
    input  logic             Hreset,
    input  logic             we,
    input  logic [IDX_W-1:0] widx,
    input  logic [31:0]      wdata,
    input  logic [IDX_W-1:0] ridx,
    output logic [31:0]      rdata
);
    logic [31:0] mem_q [NUM_REGS];
    logic [31:0] mem_d [NUM_REGS];

    always_comb begin
        mem_d = mem_q;
        if (we) mem_d[widx] = wdata;
    end

    always_ff @(posedge Hclk or negedge Hreset) begin
        if (!Hreset) mem_q <= '{default: '0};
        else mem_q <= mem_d;
    end

    assign rdata = mem_q[ridx];
endmodule

// File: rtl/apb_slave_regs.sv
// apb_slave_regs: zero-wait APB register completer with per-bank storage, protocol monitor and
// saturating transfer counters.
module apb_slave_regs
    import apb_slave_regs_pkg::*;
#(
    parameter int NUM_SLV  = APB_NUM_SLV,
    parameter int NUM_REGS = APB_NUM_REGS,
    parameter int IDX_W    = $clog2(NUM_REGS),
    parameter int CNT_W    = 16
) (
    input  logic                Hclk,
    input  logic                Hreset,
    apb_slave_regs_if.slave     apb,
    output logic                Perr,
    input  logic                err_clr,
    output logic [CNT_W-1:0]    wr_cnt,
    output logic [CNT_W-1:0]    rd_cnt
);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    apb_state_e         state_q, state_d;
    logic [NUM_SLV-1:0] sel_q, sel_d, bank_we;
    logic [31:0]        addr_q, addr_d, wdata_q, wdata_d, rdata_q, rdata_d, rd_mux;
    logic               wr_q, wr_d, perr_q, perr_d;
    logic [CNT_W-1:0]   wr_cnt_q, wr_cnt_d, rd_cnt_q, rd_cnt_d;
    logic               sel, setup, match, bus_bad, ctx_bad, done, commit, err, raw_hit;
    logic [31:0]        bank_rdata [NUM_SLV];

    assign sel     = |apb.Pselx;
    assign setup   = sel & ~apb.Penable;
    assign match   = sel & apb.Penable & (apb.Pselx == sel_q) & (apb.Paddr == addr_q) & (apb.Pwrite == wr_q);
    assign bus_bad = bad_decode(32'(apb.Pselx), apb.Paddr[1:0]);
    assign ctx_bad = bad_decode(32'(sel_q), addr_q[1:0]);

    always_ff @(posedge Hclk or negedge Hreset) begin
        if (!Hreset) state_q <= APB_IDLE;
        else state_q <= state_d;
    end

    // IDLE and ACCESS share exits; only a matching access phase advances SETUP.
    always_comb begin
        state_d = (state_q == APB_SETUP && match) ? APB_ACCESS : setup ? APB_SETUP : APB_IDLE;
    end

    always_comb begin
        done     = (state_q == APB_ACCESS) && !ctx_bad;
        commit   = done && wr_q;
        err      = (state_q == APB_SETUP) ? (!match || ctx_bad) : apb.Penable;
        raw_hit  = commit && (apb.Pselx == sel_q) && (apb.Paddr[IDX_W+1:2] == addr_q[IDX_W+1:2]);
        sel_d    = (state_d == APB_SETUP) ? apb.Pselx : sel_q;
        addr_d   = (state_d == APB_SETUP) ? apb.Paddr : addr_q;
        wr_d     = (state_d == APB_SETUP) ? apb.Pwrite : wr_q;
        // Write data is only stable in the bus access phase, one cycle before the commit edge.
        wdata_d  = (state_d == APB_ACCESS) ? apb.Pwdata : wdata_q;
        rdata_d  = (state_d != APB_SETUP || apb.Pwrite) ? rdata_q :
                   bus_bad ? APB_ERR_RDATA : raw_hit ? wdata_q : rd_mux;
        perr_d   = err | (perr_q & ~err_clr);
        wr_cnt_d = (commit && wr_cnt_q != CNT_MAX) ? wr_cnt_q + 1'b1 : wr_cnt_q;
        rd_cnt_d = (done && !wr_q && rd_cnt_q != CNT_MAX) ? rd_cnt_q + 1'b1 : rd_cnt_q;
        bank_we  = commit ? sel_q : '0;
    end

    always_comb begin
        rd_mux = '0;
        for (int i = 0; i < NUM_SLV; i++) rd_mux = apb.Pselx[i] ? bank_rdata[i] : rd_mux;
    end

    always_ff @(posedge Hclk or negedge Hreset) begin
        if (!Hreset) begin
            sel_q    <= '0;
            addr_q   <= '0;
            wr_q     <= 1'b0;
            wdata_q  <= '0;
            rdata_q  <= '0;
            perr_q   <= 1'b0;
            wr_cnt_q <= '0;
            rd_cnt_q <= '0;
        end else begin
            sel_q    <= sel_d;
            addr_q   <= addr_d;
            wr_q     <= wr_d;
            wdata_q  <= wdata_d;
            rdata_q  <= rdata_d;
            perr_q   <= perr_d;
            wr_cnt_q <= wr_cnt_d;
            rd_cnt_q <= rd_cnt_d;
        end
    end

    for (genvar s = 0; s < NUM_SLV; s++) begin : g_bank
        apb_reg_bank #(.NUM_REGS(NUM_REGS), .IDX_W(IDX_W)) u_bank (
            .Hclk  (Hclk),
            .Hreset(Hreset),
            .we    (bank_we[s]),
            .widx  (addr_q[IDX_W+1:2]),
            .wdata (wdata_q),
            .ridx  (apb.Paddr[IDX_W+1:2]),
            .rdata (bank_rdata[s])
        );
    end

    assign apb.Prdata = rdata_q;
    assign Perr       = perr_q;
    assign wr_cnt     = wr_cnt_q;
    assign rd_cnt     = rd_cnt_q;
endmodule
